// File: rtl/mac_rx_pkt_fifo_if.sv
// AXI-Stream bundle shared by the RX MAC side and the user side of the packet FIFO.
// Handshake: a beat transfers on a clock edge where tvalid & tready are both 1.
interface mac_rx_pkt_fifo_if #(
   parameter int N_SYMBOLS = 4,
   parameter int W_SYMBOL  = 8
);
   logic                          tvalid;
   logic                          tready;
   logic [N_SYMBOLS-1:0]          tkeep;
   logic [N_SYMBOLS*W_SYMBOL-1:0] tdata;
   logic                          tlast;
   logic                          tuser;

   modport master (output tvalid, tkeep, tdata, tlast, tuser, input tready);
   modport slave  (input tvalid, tkeep, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/mac_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: frames become visible to the user only once
// their last beat arrives with good status; bad, aborted or oversize frames vanish.
module mac_rx_pkt_fifo #(
   parameter int N_SYMBOLS = 4,
   parameter int W_SYMBOL  = 8,
   parameter int ADDR_W    = 9,
   parameter int W_CNT     = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clk_en,
   mac_rx_pkt_fifo_if.slave  s_axis,
   mac_rx_pkt_fifo_if.master m_axis,
   output logic [W_CNT-1:0] o_frames_ok,
   output logic [W_CNT-1:0] o_frames_drop,
   output logic             o_overflow,
   output logic [1:0]       o_wr_state
);
   localparam int W_DATA = N_SYMBOLS * W_SYMBOL;
   localparam int W_WORD = W_DATA + N_SYMBOLS + 1;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_FRAME = 2'd1,
      WR_DROP  = 2'd2
   } wr_state_t;

   wr_state_t state_q, state_d;

   logic [W_WORD-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr, wr_ptr_d;
   logic [ADDR_W:0]   wr_commit, wr_commit_d;
   logic [ADDR_W:0]   rd_fetch;
   logic [ADDR_W:0]   rd_ptr;

   logic beat, full, mem_we, ok_inc, drop_inc, ovf_d;

   // The MAC cannot be stalled, so the slave side is permanently ready.
   assign s_axis.tready = 1'b1;
   assign beat = s_axis.tvalid & i_clk_en;
   assign full = (wr_ptr - rd_ptr) == FULL_LVL;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr;
      wr_commit_d = wr_commit;
      mem_we      = 1'b0;
      ok_inc      = 1'b0;
      drop_inc    = 1'b0;
      ovf_d       = 1'b0;
      case (state_q)
         WR_IDLE, WR_FRAME: begin
            if (beat) begin
               if (!s_axis.tuser) begin
                  wr_ptr_d = wr_commit;
                  drop_inc = 1'b1;
                  state_d  = WR_IDLE;
               end else if (full) begin
                  wr_ptr_d = wr_commit;
                  drop_inc = 1'b1;
                  ovf_d    = 1'b1;
                  state_d  = s_axis.tlast ? WR_IDLE : WR_DROP;
               end else begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr + 1'b1;
                  if (s_axis.tlast) begin
                     wr_commit_d = wr_ptr + 1'b1;
                     ok_inc      = 1'b1;
                     state_d     = WR_IDLE;
                  end else begin
                     state_d = WR_FRAME;
                  end
               end
            end
         end
         WR_DROP: begin
            if (beat && (s_axis.tlast || !s_axis.tuser)) state_d = WR_IDLE;
         end
         default: state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q       <= WR_IDLE;
         wr_ptr        <= '0;
         wr_commit     <= '0;
         o_frames_ok   <= '0;
         o_frames_drop <= '0;
         o_overflow    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr     <= wr_ptr_d;
         wr_commit  <= wr_commit_d;
         o_overflow <= ovf_d;
         if (ok_inc && (o_frames_ok != '1))     o_frames_ok   <= o_frames_ok + 1'b1;
         if (drop_inc && (o_frames_drop != '1)) o_frames_drop <= o_frames_drop + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
   end

   // Read pipeline: RAM output register, then the FWFT output register.
   // rd_fetch walks the RAM; rd_ptr only advances when a beat leaves m_axis,
   // so prefetched beats keep their slots until the user really takes them.
   logic              avail, pop, out_load, rd_en;
   logic              ram_q_vld, m_valid;
   logic [W_WORD-1:0] ram_q, m_word;

   assign avail    = rd_fetch != wr_commit;
   assign pop      = m_valid & m_axis.tready;
   assign out_load = ram_q_vld & (~m_valid | pop);
   assign rd_en    = avail & (~ram_q_vld | out_load);

   always_ff @(posedge i_clk) begin
      if (rd_en) ram_q <= mem[rd_fetch[ADDR_W-1:0]];
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         rd_fetch  <= '0;
         rd_ptr    <= '0;
         ram_q_vld <= 1'b0;
         m_valid   <= 1'b0;
         m_word    <= '0;
      end else begin
         if (rd_en) rd_fetch <= rd_fetch + 1'b1;
         if (pop)   rd_ptr   <= rd_ptr + 1'b1;
         ram_q_vld <= rd_en | (ram_q_vld & ~out_load);
         m_valid   <= out_load | (m_valid & ~pop);
         if (out_load) m_word <= ram_q;
      end
   end

   assign m_axis.tvalid = m_valid;
   assign m_axis.tlast  = m_word[W_WORD-1];
   assign m_axis.tkeep  = m_word[W_DATA +: N_SYMBOLS];
   assign m_axis.tdata  = m_word[W_DATA-1:0];
   assign m_axis.tuser  = 1'b1;
   assign o_wr_state    = state_q;
endmodule

// File: tb/tb_mac_rx_pkt_fifo.sv
// Directed bench for mac_rx_pkt_fifo: frames are sent beat by beat, good frames
// are queued as expected output and checked beat by beat at the m_axis side.
module tb_mac_rx_pkt_fifo;
   localparam int N_SYMBOLS = 4;
   localparam int W_SYMBOL  = 8;
   localparam int ADDR_W    = 4;
   localparam int W_CNT     = 16;
   localparam int W_WORD    = 1 + N_SYMBOLS + N_SYMBOLS * W_SYMBOL;

   logic             i_clk = 1'b0;
   logic             i_reset = 1'b0;
   logic             i_clk_en = 1'b1;
   logic [W_CNT-1:0] o_frames_ok, o_frames_drop;
   logic             o_overflow;
   logic [1:0]       o_wr_state;

   mac_rx_pkt_fifo_if #(.N_SYMBOLS(N_SYMBOLS), .W_SYMBOL(W_SYMBOL)) s_axis ();
   mac_rx_pkt_fifo_if #(.N_SYMBOLS(N_SYMBOLS), .W_SYMBOL(W_SYMBOL)) m_axis ();

   mac_rx_pkt_fifo #(
      .N_SYMBOLS(N_SYMBOLS), .W_SYMBOL(W_SYMBOL), .ADDR_W(ADDR_W), .W_CNT(W_CNT)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en),
      .s_axis(s_axis), .m_axis(m_axis),
      .o_frames_ok(o_frames_ok), .o_frames_drop(o_frames_drop),
      .o_overflow(o_overflow), .o_wr_state(o_wr_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int out_cnt  = 0;
   logic [W_WORD-1:0] exp_q[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge i_clk) begin
      if (i_reset && m_axis.tvalid && m_axis.tready) begin
         out_cnt++;
         if (exp_q.size() == 0) chk("unexpected_beat", {m_axis.tlast, m_axis.tkeep, m_axis.tdata}, '0);
         else chk("beat", {m_axis.tlast, m_axis.tkeep, m_axis.tdata}, exp_q.pop_front());
      end
   end

   // ---------------- drivers ----------------
   task automatic send_beat(input logic [31:0] data, input logic [3:0] keep,
                            input logic last, input logic user);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = data;
      s_axis.tkeep  = keep;
      s_axis.tlast  = last;
      s_axis.tuser  = user;
      @(posedge i_clk);
      #1;
      s_axis.tvalid = 1'b0;
   endtask

   // Frame of n beats, data = base+i, last beat has a partial keep.
   task automatic send_frame(input int n, input logic [31:0] base, input logic good);
      for (int i = 0; i < n; i++) begin
         logic last;
         logic [3:0] keep;
         last = (i == n - 1);
         keep = last ? 4'b0111 : 4'b1111;
         if (good) exp_q.push_back({last, keep, base + 32'(i)});
         send_beat(base + 32'(i), keep, last, last ? good : 1'b1);
      end
   endtask

   task automatic do_reset();
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      exp_q.delete();
   endtask

   task automatic wait_drain(input string tag);
      int budget;
      budget = 200;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge i_clk);
         #1;
         budget--;
      end
      repeat (4) @(posedge i_clk);
      #1;
      chk(tag, exp_q.size(), 0);
      chk({tag, "_idle"}, m_axis.tvalid, 1'b0);
   endtask

   // ---------------- test sequence ----------------
   int start_cnt;

   initial begin
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;
      s_axis.tkeep  = '0;
      s_axis.tlast  = 1'b0;
      s_axis.tuser  = 1'b0;
      m_axis.tready = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      chk("rst_tvalid", m_axis.tvalid, 1'b0);
      chk("rst_ok", o_frames_ok, 0);
      chk("rst_drop", o_frames_drop, 0);
      chk("rst_ovf", o_overflow, 1'b0);
      chk("rst_state", o_wr_state, 2'd0);

      // 1: 16-beat good frame, check commit-to-valid latency
      send_frame(16, 32'h1000_0000, 1'b1);
      chk("t1_ok", o_frames_ok, 1);
      chk("t1_tvalid_c0", m_axis.tvalid, 1'b0);
      @(posedge i_clk); #1;
      chk("t1_tvalid_c1", m_axis.tvalid, 1'b0);
      @(posedge i_clk); #1;
      chk("t1_tvalid_c2", m_axis.tvalid, 1'b1);
      wait_drain("t1_drain");

      // 2: bad-status frame followed by a good frame
      do_reset();
      send_frame(8, 32'h2000_0000, 1'b0);
      send_frame(4, 32'h2100_0000, 1'b1);
      wait_drain("t2_drain");
      chk("t2_ok", o_frames_ok, 1);
      chk("t2_drop", o_frames_drop, 1);

      // 3: aborted frame (tuser=0, no tlast) followed by a good frame
      do_reset();
      for (int i = 0; i < 5; i++) send_beat(32'h3000_0000 + 32'(i), 4'hF, 1'b0, 1'b1);
      send_beat(32'h3000_00FF, 4'hF, 1'b0, 1'b0);
      chk("t3_state_abort", o_wr_state, 2'd0);
      send_frame(3, 32'h3100_0000, 1'b1);
      wait_drain("t3_drain");
      chk("t3_ok", o_frames_ok, 1);
      chk("t3_drop", o_frames_drop, 1);

      // 4: overflow with the output stalled
      do_reset();
      m_axis.tready = 1'b0;
      send_frame(12, 32'h4000_0000, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         send_beat(32'h4100_0000 + 32'(i), 4'hF, i == 10, 1'b1);
         if (i == 4) chk("t4_ovf_b4", o_overflow, 1'b0);
         if (i == 5) begin
            chk("t4_ovf_b5", o_overflow, 1'b1);
            chk("t4_state_drop", o_wr_state, 2'd2);
         end
         if (i == 6) chk("t4_ovf_b6", o_overflow, 1'b0);
         if (i == 9) chk("t4_state_b9", o_wr_state, 2'd2);
      end
      chk("t4_state_end", o_wr_state, 2'd0);
      chk("t4_ok", o_frames_ok, 1);
      chk("t4_drop", o_frames_drop, 1);
      m_axis.tready = 1'b1;
      wait_drain("t4_drain");

      // 5: clock-enable gating, junk end-of-frame on disabled cycles
      do_reset();
      start_cnt = out_cnt;
      for (int c = 0; c < 16; c++) begin
         logic en;
         en = (c % 2 == 0);
         i_clk_en = en;
         if (en) begin
            exp_q.push_back({c == 14, 4'hF, 32'h5000_0000 + 32'(c)});
            send_beat(32'h5000_0000 + 32'(c), 4'hF, c == 14, 1'b1);
         end else begin
            send_beat(32'hDEAD_0000 + 32'(c), 4'hF, 1'b1, 1'b0);
         end
      end
      i_clk_en = 1'b1;
      wait_drain("t5_drain");
      chk("t5_count", out_cnt - start_cnt, 8);
      chk("t5_ok", o_frames_ok, 1);
      chk("t5_drop", o_frames_drop, 0);

      // 6: reset while a committed frame is pending and another is mid-write
      do_reset();
      m_axis.tready = 1'b0;
      send_frame(4, 32'h6000_0000, 1'b1);
      for (int i = 0; i < 3; i++) send_beat(32'h6100_0000 + 32'(i), 4'hF, 1'b0, 1'b1);
      chk("t6_pending", m_axis.tvalid, 1'b1);
      chk("t6_ok_pre", o_frames_ok, 1);
      i_reset = 1'b0;
      @(posedge i_clk); #1;
      chk("t6_rst_tvalid", m_axis.tvalid, 1'b0);
      chk("t6_rst_ok", o_frames_ok, 0);
      chk("t6_rst_drop", o_frames_drop, 0);
      chk("t6_rst_state", o_wr_state, 2'd0);
      i_reset = 1'b1;
      exp_q.delete();
      m_axis.tready = 1'b1;
      send_frame(2, 32'h6200_0000, 1'b1);
      wait_drain("t6_drain");
      chk("t6_ok", o_frames_ok, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
